// File: rtl/mm_tile_sequencer_if.sv
// Handshake bundle between the tile sequencer and its surroundings
// (command source, feature buffer, matrix engine, accumulator, output sink).
interface mm_tile_sequencer_if #(
  parameter int TW = 4
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [TW-1:0] cmd_rows_m1;
  logic [TW-1:0] cmd_cols_m1;
  logic          tile_req_valid;
  logic          tile_req_ready;
  logic [TW-1:0] tile_row;
  logic [TW-1:0] tile_col;
  logic          tile_data_valid;
  logic          mm_input_valid;
  logic          mm_add_valid;
  logic          acc_en;
  logic          acc_clear;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_row;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  cmd_valid, cmd_rows_m1, cmd_cols_m1, tile_req_ready,
           tile_data_valid, mm_add_valid, out_ready,
    output cmd_ready, tile_req_valid, tile_row, tile_col, mm_input_valid,
           acc_en, acc_clear, out_valid, out_row, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_rows_m1, cmd_cols_m1, tile_req_ready,
           tile_data_valid, mm_add_valid, out_ready,
    input  cmd_ready, tile_req_valid, tile_row, tile_col, mm_input_valid,
           acc_en, acc_clear, out_valid, out_row, busy, done, err
  );
endinterface

// File: rtl/mm_tile_sequencer.sv
// Walks an R x C tile grid row-major, driving fetch requests, engine issue
// pulses, accumulator strobes and per-row output handoff, with a result watchdog.
module mm_tile_sequencer #(
  parameter int TW          = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CW          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mm_tile_sequencer_if.master   sq_if
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_RES  = 3'd4;
  localparam logic [2:0] S_ACC       = 3'd5;
  localparam logic [2:0] S_WRITE     = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] r_q, r_d;
  logic [TW-1:0] c_q, c_d;
  logic [TW-1:0] rows_q, rows_d;
  logic [TW-1:0] cols_q, cols_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  logic          proto_err_s;

  logic          cmd_ready_q;
  logic          tile_req_valid_q;
  logic          mm_input_valid_q;
  logic          acc_en_q;
  logic          acc_clear_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  // Engine results or fetched data arriving when not expected
  always_comb begin
    proto_err_s = (sq_if.mm_add_valid    && (state_q != S_WAIT_RES)) ||
                  (sq_if.tile_data_valid && (state_q != S_WAIT_DATA));
  end

  // Next-state, tile counters, watchdog and sticky error
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (sq_if.cmd_valid) begin
          rows_d  = sq_if.cmd_rows_m1;
          cols_d  = sq_if.cmd_cols_m1;
          r_d     = {TW{1'b0}};
          c_d     = {TW{1'b0}};
          err_d   = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (sq_if.tile_req_ready) begin
          state_d = S_WAIT_DATA;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT_DATA: begin
        if (sq_if.tile_data_valid) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
      S_ISSUE: begin
        wd_d    = {CW{1'b0}};
        state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        // A result landing on the expiry cycle still counts as on time
        if (sq_if.mm_add_valid) begin
          state_d = S_ACC;
        end else if (wd_q == CW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d    = wd_q + CW'(1'b1);
        end
      end
      S_ACC: begin
        if (c_q < cols_q) begin
          c_d     = c_q + TW'(1'b1);
          state_d = S_REQ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!sq_if.out_ready) begin
          state_d = S_WRITE;
        end else if (r_q < rows_q) begin
          r_d     = r_q + TW'(1'b1);
          c_d     = {TW{1'b0}};
          state_d = S_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (proto_err_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // State, counters and output strobes decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      r_q              <= {TW{1'b0}};
      c_q              <= {TW{1'b0}};
      rows_q           <= {TW{1'b0}};
      cols_q           <= {TW{1'b0}};
      wd_q             <= {CW{1'b0}};
      err_q            <= 1'b0;
      cmd_ready_q      <= 1'b1;
      tile_req_valid_q <= 1'b0;
      mm_input_valid_q <= 1'b0;
      acc_en_q         <= 1'b0;
      acc_clear_q      <= 1'b0;
      out_valid_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      r_q              <= r_d;
      c_q              <= c_d;
      rows_q           <= rows_d;
      cols_q           <= cols_d;
      wd_q             <= wd_d;
      err_q            <= err_d;
      cmd_ready_q      <= (state_d == S_IDLE);
      tile_req_valid_q <= (state_d == S_REQ);
      mm_input_valid_q <= (state_d == S_ISSUE);
      acc_en_q         <= (state_d == S_ACC);
      acc_clear_q      <= (state_d == S_ACC) && (c_d == {TW{1'b0}});
      out_valid_q      <= (state_d == S_WRITE);
      busy_q           <= (state_d != S_IDLE);
      done_q           <= (state_d == S_DONE);
    end
  end

  assign sq_if.cmd_ready      = cmd_ready_q;
  assign sq_if.tile_req_valid = tile_req_valid_q;
  assign sq_if.tile_row       = r_q;
  assign sq_if.tile_col       = c_q;
  assign sq_if.mm_input_valid = mm_input_valid_q;
  assign sq_if.acc_en         = acc_en_q;
  assign sq_if.acc_clear      = acc_clear_q;
  assign sq_if.out_valid      = out_valid_q;
  assign sq_if.out_row        = r_q;
  assign sq_if.busy           = busy_q;
  assign sq_if.done           = done_q;
  assign sq_if.err            = err_q;

endmodule
